prio_enc_scan: RTL and testbench

PRIO_ENC_SCAN -- requirements
Module: prio_enc_scan

---
 rtl/prio_enc_scan.sv | 118 +++++++++++
 tb/tb_prio_enc_scan.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/prio_enc_scan.sv
// rtl/prio_enc_scan.sv - registered priority encoder with change counter and 2-digit hex scan display
// Optional build macro: PRIO_SCAN_BLANK_EN blanks the display while valid is low.
module prio_enc_scan #(
    parameter int IN_W     = 16,
    parameter int SCAN_DIV = 1000,
    localparam int YW      = $clog2(IN_W),
    localparam int SW      = $clog2(SCAN_DIV)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [IN_W-1:0] x,
    input  logic            clr,
    output logic [YW-1:0]   y,
    output logic            valid,
    output logic            chg,
    output logic [7:0]      cnt,
    output logic [7:0]      seg,
    output logic [1:0]      an
);

`ifdef PRIO_SCAN_BLANK_EN
    localparam logic [7:0] SEG_RST = 8'hFF;
`else
    localparam logic [7:0] SEG_RST = 8'h03;
`endif

    logic [YW-1:0] y_q, y_d, enc;
    logic          valid_q, valid_d;
    logic          chg_q, chg_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [SW-1:0] scan_q, scan_d;
    logic          sel_q, sel_d;
    logic          scan_wrap;
    logic [7:0]    disp;
    logic [3:0]    nib;
    logic [7:0]    seg_q, seg_d;
    logic [1:0]    an_q, an_d;

    // Segment pattern a..g,dp, active high; the output inverts it.
    function automatic logic [7:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 8'hFC;
            4'h1: hex7 = 8'h60;
            4'h2: hex7 = 8'hDA;
            4'h3: hex7 = 8'hF2;
            4'h4: hex7 = 8'h66;
            4'h5: hex7 = 8'hB6;
            4'h6: hex7 = 8'hBE;
            4'h7: hex7 = 8'hE0;
            4'h8: hex7 = 8'hFE;
            4'h9: hex7 = 8'hF6;
            4'hA: hex7 = 8'hEE;
            4'hB: hex7 = 8'h3E;
            4'hC: hex7 = 8'h9C;
            4'hD: hex7 = 8'h7A;
            4'hE: hex7 = 8'h9E;
            default: hex7 = 8'h8E;
        endcase
    endfunction

    always_comb begin
        enc = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (x[i]) enc = YW'(i);
        end
        valid_d = en & (|x);
        y_d     = valid_d ? enc : '0;
        chg_d   = ({valid_d, y_d} != {valid_q, y_q});

        cnt_d = cnt_q;
        if (clr) cnt_d = 8'd0;
        else if (chg_q && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;

        scan_wrap = (scan_q == SW'(SCAN_DIV - 1));
        scan_d    = scan_wrap ? '0 : scan_q + SW'(1);
        sel_d     = sel_q ^ scan_wrap;

        // Decode against the digit about to be selected so seg and an move together.
        disp  = 8'(y_q);
        nib   = sel_d ? disp[7:4] : disp[3:0];
        seg_d = ~hex7(nib);
`ifdef PRIO_SCAN_BLANK_EN
        if (!valid_q) seg_d = 8'hFF;
`endif
        an_d = sel_d ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q     <= '0;
            valid_q <= 1'b0;
            chg_q   <= 1'b0;
            cnt_q   <= 8'd0;
            scan_q  <= '0;
            sel_q   <= 1'b0;
            seg_q   <= SEG_RST;
            an_q    <= 2'b10;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
            chg_q   <= chg_d;
            cnt_q   <= cnt_d;
            scan_q  <= scan_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign y     = y_q;
    assign valid = valid_q;
    assign chg   = chg_q;
    assign cnt   = cnt_q;
    assign seg   = seg_q;
    assign an    = an_q;

endmodule

// File: tb/tb_prio_enc_scan.sv
// tb/tb_prio_enc_scan.sv - directed table and sequence bench for prio_enc_scan
module tb_prio_enc_scan;

    localparam int IN_W = 16;
    localparam int SCAN_DIV = 4;

`ifdef PRIO_SCAN_BLANK_EN
    localparam logic [7:0] SEG_IDLE = 8'hFF;
`else
    localparam logic [7:0] SEG_IDLE = 8'h03;
`endif

    logic        clk = 1'b0;
    logic        rst_n, en, clr;
    logic [15:0] x;
    logic [3:0]  y;
    logic        valid, chg;
    logic [7:0]  cnt, seg;
    logic [1:0]  an;

    int checks = 0;
    int errors = 0;

    prio_enc_scan #(.IN_W(IN_W), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .x(x), .clr(clr),
        .y(y), .valid(valid), .chg(chg), .cnt(cnt), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [15:0] x;
        logic [3:0]  exp_y;
        logic        exp_valid;
        logic        exp_chg;
    } vec_t;

    vec_t vecs[12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [7:0] cnt_exp;
        logic       prev_chg;
        logic [1:0] an_prev;
        logic [1:0] an_exp;
        bit         found;

        vecs[0]  = '{1'b1, 16'h0000, 4'd0,  1'b0, 1'b0};
        vecs[1]  = '{1'b1, 16'h8421, 4'd15, 1'b1, 1'b1};
        vecs[2]  = '{1'b1, 16'h0006, 4'd2,  1'b1, 1'b1};
        vecs[3]  = '{1'b1, 16'h0006, 4'd2,  1'b1, 1'b0};
        vecs[4]  = '{1'b1, 16'h0006, 4'd2,  1'b1, 1'b0};
        vecs[5]  = '{1'b0, 16'hFFFF, 4'd0,  1'b0, 1'b1};
        vecs[6]  = '{1'b1, 16'hFFFF, 4'd15, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 16'h0001, 4'd0,  1'b1, 1'b1};
        vecs[8]  = '{1'b1, 16'h0000, 4'd0,  1'b0, 1'b1};
        vecs[9]  = '{1'b0, 16'h0000, 4'd0,  1'b0, 1'b0};
        vecs[10] = '{1'b1, 16'h0080, 4'd7,  1'b1, 1'b1};
        vecs[11] = '{1'b1, 16'h00C0, 4'd7,  1'b1, 1'b0};

        rst_n = 1'b0; en = 1'b1; clr = 1'b0; x = 16'hFFFF;
        step();
        step();
        check("rst_y", 32'(y), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_chg", 32'(chg), 32'd0);
        check("rst_cnt", 32'(cnt), 32'd0);
        check("rst_an", 32'(an), 32'b10);
        check("rst_seg", 32'(seg), 32'(SEG_IDLE));

        rst_n = 1'b1;
        cnt_exp = 8'd0;
        prev_chg = 1'b0;
        for (int i = 0; i < 12; i++) begin
            en = vecs[i].en;
            x  = vecs[i].x;
            step();
            if (prev_chg && cnt_exp != 8'hFF) cnt_exp = cnt_exp + 8'd1;
            prev_chg = vecs[i].exp_chg;
            check($sformatf("vec%0d_y", i), 32'(y), 32'(vecs[i].exp_y));
            check($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_chg", i), 32'(chg), 32'(vecs[i].exp_chg));
            check($sformatf("vec%0d_cnt", i), 32'(cnt), 32'(cnt_exp));
        end

        en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            x = (i % 2 == 0) ? 16'h0001 : 16'h0002;
            step();
        end
        check("sat_chg", 32'(chg), 32'd1);
        check("sat_cnt", 32'(cnt), 32'd255);
        clr = 1'b1;
        x = 16'h0001;
        step();
        clr = 1'b0;
        check("clr_cnt", 32'(cnt), 32'd0);
        step();
        check("post_clr_cnt", 32'(cnt), 32'd1);

        x = 16'h0800;
        step();
        step();
        step();
        check("scan_y", 32'(y), 32'd11);
        an_prev = an;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (an !== an_prev) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL scan_toggle: an stuck at %b expected a change within 10 cycles", an);
        end
        an_prev = an;
        for (int k = 1; k < 12; k++) begin
            step();
            an_exp = ((k / 4) % 2 == 1) ? ~an_prev : an_prev;
            check($sformatf("scan_an_k%0d", k), 32'(an), 32'(an_exp));
            check($sformatf("scan_seg_k%0d", k), 32'(seg), (an_exp == 2'b10) ? 32'hC1 : 32'h03);
        end

        x = 16'h0000;
        step();
        step();
        step();
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("idle_seg_k%0d", k), 32'(seg), 32'(SEG_IDLE));
        end

        x = 16'h0010;
        step();
        step();
        rst_n = 1'b0;
        clr = 1'b0;
        step();
        rst_n = 1'b1;
        x = 16'h0000;
        check("mid_rst_an", 32'(an), 32'b10);
        check("mid_rst_cnt", 32'(cnt), 32'd0);
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_seg", 32'(seg), 32'(SEG_IDLE));
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("restart_an_k%0d", k), 32'(an), (k == 4) ? 32'b01 : 32'b10);
        end
        check("restart_chg", 32'(chg), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
